// File: rtl/mem_check.sv
// Memory pattern checker: streams word reads from base_addr, compares each
// returned word with a captured pattern, and reports mismatch statistics.
module mem_check #(
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic [CNT_WIDTH-1:0] word_count,
    input  logic [31:0]          pattern,
    output logic [31:0]          mem_addr,
    output logic                 mem_read,
    input  logic [31:0]          mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] mismatch_count,
    output logic [31:0]          first_bad_addr,
    output logic [31:0]          first_bad_data,
    output logic                 align_err
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_e;

    state_e                        state_q, state_d;
    logic [31:0]                   addr_q;
    logic [CNT_WIDTH-1:0]          remain_q;
    logic [31:0]                   pattern_q;
    logic [CNT_WIDTH-1:0]          mismatch_q;
    logic [31:0]                   fb_addr_q, fb_data_q;
    logic                          align_q;
    // Read-issue valid/address delayed to line up with the returning data.
    logic [MEM_LATENCY-1:0]        vld_pipe_q;
    logic [MEM_LATENCY-1:0][31:0]  addr_pipe_q;
    logic                          pend_early;
    logic                          start_ok;

    assign start_ok = (state_q == IDLE) && start;

    always_comb begin
        pend_early = 1'b0;
        for (int i = 0; i < MEM_LATENCY - 1; i++) pend_early = pend_early | vld_pipe_q[i];
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = (word_count == '0 || base_addr[1:0] != 2'b00) ? FINISH : SCAN;
            SCAN:   if (remain_q == CNT_WIDTH'(1)) state_d = DRAIN;
            DRAIN:  if (!pend_early) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read = (state_q == SCAN);
        mem_addr = mem_read ? addr_q : 32'd0;
        busy     = (state_q == SCAN) || (state_q == DRAIN);
        done     = (state_q == FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            remain_q    <= '0;
            pattern_q   <= '0;
            mismatch_q  <= '0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            align_q     <= 1'b0;
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
        end else begin
            vld_pipe_q[0]  <= mem_read;
            addr_pipe_q[0] <= mem_addr;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end

            if (state_q == SCAN) begin
                addr_q   <= addr_q + 32'd4;
                remain_q <= remain_q - CNT_WIDTH'(1);
            end

            if (vld_pipe_q[MEM_LATENCY-1] && mem_rdata != pattern_q) begin
                if (mismatch_q != '1) mismatch_q <= mismatch_q + CNT_WIDTH'(1);
                if (mismatch_q == '0) begin
                    fb_addr_q <= addr_pipe_q[MEM_LATENCY-1];
                    fb_data_q <= mem_rdata;
                end
            end

            if (start_ok) begin
                addr_q     <= base_addr;
                remain_q   <= word_count;
                pattern_q  <= pattern;
                mismatch_q <= '0;
                fb_addr_q  <= '0;
                fb_data_q  <= '0;
                align_q    <= (base_addr[1:0] != 2'b00);
            end
        end
    end

    assign mismatch_count = mismatch_q;
    assign first_bad_addr = fb_addr_q;
    assign first_bad_data = fb_data_q;
    assign align_err      = align_q;

endmodule

// File: tb/tb_mem_check.sv
// Directed bench for mem_check with a byte-addressed little-endian memory model.
module tb_mem_check;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] base_addr, pattern, mem_addr, mem_rdata;
    logic [15:0] word_count, mismatch_count;
    logic        mem_read, busy, done, align_err;
    logic [31:0] first_bad_addr, first_bad_data;

    int total = 0;
    int bad   = 0;
    int addr0_viol = 0;
    logic [7:0]  mem_b [0:255];
    logic [31:0] rd_q [$];

    always #5 clk = ~clk;

    mem_check #(.CNT_WIDTH(16), .MEM_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .pattern(pattern), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .mismatch_count(mismatch_count), .first_bad_addr(first_bad_addr),
        .first_bad_data(first_bad_data), .align_err(align_err)
    );

    // One-cycle-latency read port, little-endian byte lanes.
    always @(posedge clk)
        if (mem_read)
            mem_rdata <= {mem_b[mem_addr[7:0] + 8'd3], mem_b[mem_addr[7:0] + 8'd2],
                          mem_b[mem_addr[7:0] + 8'd1], mem_b[mem_addr[7:0]]};

    always @(negedge clk)
        if (!mem_read && mem_addr !== 32'd0) addr0_viol++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        mem_b[a]   = w[7:0];
        mem_b[a+1] = w[15:8];
        mem_b[a+2] = w[23:16];
        mem_b[a+3] = w[31:24];
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] n, input logic [31:0] p);
        @(negedge clk);
        base_addr = b; word_count = n; pattern = p; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rd_q.delete();
    endtask

    // Walks cycles 1.. after the start edge; optionally pulses start at cycle inj.
    task automatic wait_done(input int inj, output int dc, output logic busy1, output logic busy_dn);
        dc = -1; busy1 = 1'bx; busy_dn = 1'bx;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) busy1 = busy;
            if (mem_read) rd_q.push_back(mem_addr);
            if (done) begin dc = i; busy_dn = busy; return; end
            if (i == inj) begin
                base_addr = 32'd8; word_count = 16'd4; pattern = 32'hDEADBEEF; start = 1'b1;
            end
        end
    endtask

    task automatic check_reads(input string tag, input logic [31:0] b, input int n);
        chk({tag, "_nreads"}, rd_q.size(), n);
        for (int k = 0; k < n && k < rd_q.size(); k++)
            chk({tag, "_raddr"}, rd_q[k], b + 32'(4 * k));
    endtask

    int   dc, dpulses;
    logic b1, bd;

    initial begin
        for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
        for (int a = 8; a <= 20; a += 4) put_word(a, 32'hDEADBEEF);
        put_word(24, 32'h0);
        for (int a = 28; a <= 40; a += 4) put_word(a, 32'h00007FFF);
        put_word(36, 32'h00007FFE);

        reset = 1'b1; start = 1'b0; base_addr = 0; word_count = 0; pattern = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mread", mem_read, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mism", mismatch_count, 0);
        chk("rst_fba", first_bad_addr, 0);
        chk("rst_fbd", first_bad_data, 0);
        chk("rst_align", align_err, 0);
        reset = 1'b0;

        // All-match four-word scan
        do_start(32'd8, 16'd4, 32'hDEADBEEF);
        wait_done(0, dc, b1, bd);
        chk("a_done_cyc", dc, 6);
        chk("a_busy1", b1, 1);
        chk("a_busy_fin", bd, 0);
        check_reads("a", 32'd8, 4);
        chk("a_mism", mismatch_count, 0);
        chk("a_fbd", first_bad_data, 0);
        chk("a_align", align_err, 0);
        @(negedge clk);
        chk("a_done_1cyc", done, 0);

        // Single word of zeros
        do_start(32'd24, 16'd1, 32'h0);
        wait_done(0, dc, b1, bd);
        chk("b_done_cyc", dc, 3);
        check_reads("b", 32'd24, 1);
        chk("b_mism", mismatch_count, 0);

        // One bad word in the middle
        do_start(32'd28, 16'd4, 32'h00007FFF);
        wait_done(0, dc, b1, bd);
        chk("c_done_cyc", dc, 6);
        check_reads("c", 32'd28, 4);
        chk("c_mism", mismatch_count, 1);
        chk("c_fba", first_bad_addr, 36);
        chk("c_fbd", first_bad_data, 32'h00007FFE);
        repeat (3) @(negedge clk);
        chk("c_hold_mism", mismatch_count, 1);
        chk("c_hold_fba", first_bad_addr, 36);

        // Zero-length request
        do_start(32'd8, 16'd0, 32'hDEADBEEF);
        wait_done(0, dc, b1, bd);
        chk("d_done_cyc", dc, 1);
        chk("d_nreads", rd_q.size(), 0);
        chk("d_busy", bd, 0);
        chk("d_align", align_err, 0);
        chk("d_mism_clr", mismatch_count, 0);
        chk("d_fba_clr", first_bad_addr, 0);

        // Misaligned base
        do_start(32'h0000000A, 16'd4, 32'hDEADBEEF);
        wait_done(0, dc, b1, bd);
        chk("e_done_cyc", dc, 1);
        chk("e_nreads", rd_q.size(), 0);
        chk("e_align", align_err, 1);

        // Reset in the middle of a scan
        do_start(32'd8, 16'd4, 32'h12345678);
        @(negedge clk);
        @(negedge clk);
        chk("f_mread_c2", mem_read, 1);
        chk("f_maddr_c2", mem_addr, 12);
        reset = 1'b1;
        @(negedge clk);
        chk("f_busy", busy, 0);
        chk("f_mread", mem_read, 0);
        chk("f_maddr", mem_addr, 0);
        chk("f_done", done, 0);
        chk("f_mism", mismatch_count, 0);
        chk("f_align", align_err, 0);
        reset = 1'b0;
        dpulses = 0;
        repeat (8) begin @(negedge clk); if (done) dpulses++; end
        chk("f_no_done", dpulses, 0);
        do_start(32'd8, 16'd4, 32'hDEADBEEF);
        wait_done(0, dc, b1, bd);
        chk("f_re_done_cyc", dc, 6);
        check_reads("f_re", 32'd8, 4);
        chk("f_re_mism", mismatch_count, 0);

        // Start during a scan must be ignored
        do_start(32'd28, 16'd4, 32'h00007FFF);
        wait_done(3, dc, b1, bd);
        chk("g_done_cyc", dc, 6);
        check_reads("g", 32'd28, 4);
        chk("g_mism", mismatch_count, 1);
        chk("g_fba", first_bad_addr, 36);
        chk("g_fbd", first_bad_data, 32'h00007FFE);
        repeat (4) @(negedge clk);
        chk("g_idle_busy", busy, 0);

        chk("addr_zero_when_idle", addr0_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_check.md
MEM_CHECK -- requirements
Module: mem_check

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of word_count and mismatch_count.
REQ-002 SHALL have parameter MEM_LATENCY, fixed at 1: read data returns exactly one clk edge after the address is presented.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
REQ-006 base_addr  input  32  byte address of first word, captured on accepted start.
REQ-007 word_count  input  CNT_WIDTH  number of 32-bit words to check, captured on accepted start.
REQ-008 pattern  input  32  expected word value, captured on accepted start.
REQ-009 mem_addr  output  32  byte address of the word read request.
REQ-010 mem_read  output  1  read strobe; mem_addr is valid while high.
REQ-011 mem_rdata  input  32  little-endian word: byte at mem_addr is bits [7:0], mem_addr+3 is bits [31:24].
REQ-012 busy  output  1  high from the cycle after an accepted start until done.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 mismatch_count  output  CNT_WIDTH  number of words unequal to pattern.
REQ-015 first_bad_addr / first_bad_data  output  32 each  address and data of the first mismatching word.
REQ-016 align_err  output  1  base_addr[1:0] != 0 on the last accepted start.

Function
REQ-017 FSM states SHALL be IDLE, SCAN, DRAIN, FINISH.
REQ-018 IDLE + start: aligned, word_count>0 -> SCAN; word_count==0 or misaligned -> FINISH with no memory reads.
REQ-019 On an accepted start, mismatch_count, first_bad_*, and align_err SHALL clear. align_err SHALL then be set if base_addr[1:0]!=0.
REQ-020 SCAN SHALL assert mem_read for exactly word_count consecutive cycles, addresses base_addr, +4, +8, ... (32-bit wrap-around permitted), then go to DRAIN.
REQ-021 Each cycle after a read cycle, mem_rdata SHALL be compared with pattern. On inequality: mismatch_count++ (saturating at all-ones); if it was 0, first_bad_addr/data SHALL capture that word's address and data.
REQ-022 DRAIN SHALL compare the final word for one cycle, then go to FINISH.
REQ-023 FINISH SHALL assert done for one cycle, then return to IDLE; busy SHALL be low in FINISH.
REQ-024 Timing: start sampled at edge 0 -> mem_read high cycles 1..N -> done high at cycle N+2. For N=0 or misaligned: done at cycle 1.
REQ-025 start while busy or in FINISH SHALL be ignored. Results SHALL hold until the next accepted start.
REQ-026 mem_addr SHALL be 0 whenever mem_read is low.

Reset
REQ-027 reset SHALL force IDLE on the next edge and zero all outputs: busy, done, mem_read, mem_addr, mismatch_count, first_bad_addr, first_bad_data, align_err.
REQ-028 reset SHALL take priority over start and over an in-progress scan. An aborted scan SHALL produce no done pulse.

Verification
REQ-029 Words 8..20 = 0xDEADBEEF (bytes ef,be,ad,de); start base=8, N=4, pattern=0xDEADBEEF -> reads at 8,12,16,20; done at cycle 6; mismatch_count=0.
REQ-030 Word 24 = 0x00000000; base=24, N=1, pattern=0 -> one read at 24; done at cycle 3; mismatch_count=0.
REQ-031 Words 28..40 = 0x00007FFF except word 36 = 0x00007FFE; base=28, N=4, pattern=0x00007FFF -> mismatch_count=1, first_bad_addr=36, first_bad_data=0x00007FFE.
REQ-032 Two cases, each expecting done at cycle 1 and no mem_read: N=0 -> align_err=0; base=0x0A, N=4 -> align_err=1.
REQ-033 reset asserted at cycle 2 of the REQ-029 scan -> all outputs zero next edge, no done; a fresh start then completes normally.
REQ-034 start pulsed at cycle 3 of a scan -> ignored; the original scan result is unchanged.
